muldiv_ctrl: RTL and testbench

- Sequencer for the shared HI/LO multiply/divide resource, placed in the execute stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the exec stage and runs a pipelined multiplier or an iterative radix-2 restoring divider.
- Raises a stall request to the hazard unit while busy, then writes HI/LO via dedicated write ports.
- Handles pipeline flush (exception) at any point in the operation.

---
 rtl/muldiv_ctrl.sv | 167 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the execute stage: pipelined multiply, radix-2 restoring
// divide, MTHI/MTLO pass-through, stall generation and flush cancellation.
module muldiv_ctrl #(
  parameter int unsigned MUL_STAGES = 2,
  parameter int unsigned DIV_BITS   = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  localparam int unsigned MaxCnt = (MUL_STAGES > DIV_BITS) ? MUL_STAGES : DIV_BITS;
  localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [32:0]       r_mul_a;
  logic [32:0]       r_mul_b;
  logic [31:0]       r_rem;
  logic [31:0]       r_quot;
  logic [31:0]       r_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [31:0]       r_hi;
  logic [31:0]       r_lo;

  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic [31:0] w_a_abs;
  logic [31:0] w_b_abs;
  logic [63:0] w_mul_a64;
  logic [63:0] w_mul_b64;
  logic [63:0] w_prod;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nxt;
  logic [31:0] w_quot_nxt;

  assign w_accept = (r_state == StIdle) & req_valid & ~flush;
  assign w_is_mul = (req_op[2:1] == 2'b00);
  assign w_is_div = (req_op[2:1] == 2'b01);
  assign w_signed = ~req_op[0];
  assign w_a_abs  = (w_signed & srca[31]) ? (~srca + 32'd1) : srca;
  assign w_b_abs  = (w_signed & srcb[31]) ? (~srcb + 32'd1) : srcb;

  // Operands are already 33-bit sign/zero extended, so one signed product covers both flavours.
  assign w_mul_a64 = {{31{r_mul_a[32]}}, r_mul_a};
  assign w_mul_b64 = {{31{r_mul_b[32]}}, r_mul_b};
  assign w_prod    = w_mul_a64 * w_mul_b64;

  // Bit 32 of the difference is the borrow: clear means the shifted remainder covers the divisor.
  assign w_rem_sh   = {r_rem, r_quot[31]};
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_ge       = ~w_diff[32];
  assign w_rem_nxt  = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
  assign w_quot_nxt = {r_quot[30:0], w_ge};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_rem   <= '0;
      r_quot  <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept && w_is_mul) begin
            r_mul_a <= {w_signed & srca[31], srca};
            r_mul_b <= {w_signed & srcb[31], srcb};
            r_cnt   <= CntW'(MUL_STAGES - 1);
            r_state <= StMul;
          end else if (w_accept && w_is_div) begin
            if (srcb == '0) begin
              r_hi    <= srca;
              r_lo    <= 32'hFFFF_FFFF;
              r_state <= StDone;
            end else begin
              r_rem   <= '0;
              r_quot  <= w_a_abs;
              r_div   <= w_b_abs;
              r_neg_q <= w_signed & (srca[31] ^ srcb[31]);
              r_neg_r <= w_signed & srca[31];
              r_cnt   <= CntW'(DIV_BITS - 1);
              r_state <= StDiv;
            end
          end
        end
        StMul: begin
          if (flush) begin
            r_state <= StIdle;
          end else if (r_cnt == '0) begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StDiv: begin
          if (flush) begin
            r_state <= StIdle;
          end else begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            if (r_cnt == '0) begin
              r_lo    <= r_neg_q ? (~w_quot_nxt + 32'd1) : w_quot_nxt;
              r_hi    <= r_neg_r ? (~w_rem_nxt + 32'd1) : w_rem_nxt;
              r_state <= StDone;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy      = (r_state != StIdle);
  assign stall_req = ~flush & (((r_state == StIdle) & req_valid & ~req_op[2]) |
                               (r_state == StMul) | (r_state == StDiv));

  always_comb begin
    hi_we    = 1'b0;
    lo_we    = 1'b0;
    hi_wdata = '0;
    lo_wdata = '0;
    if (!flush) begin
      if (r_state == StDone) begin
        hi_we    = 1'b1;
        lo_we    = 1'b1;
        hi_wdata = r_hi;
        lo_wdata = r_lo;
      end else if (w_accept && (req_op == 3'd4)) begin
        hi_we    = 1'b1;
        hi_wdata = srca;
      end else if (w_accept && (req_op == 3'd5)) begin
        lo_we    = 1'b1;
        lo_wdata = srca;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO writes are queued at issue and popped
// whenever the DUT asserts a write enable.
module tb_muldiv_ctrl;

  localparam int unsigned MulStages = 2;

  typedef struct packed {
    logic        hwe;
    logic        lwe;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        flush = 1'b0;
  logic        stall_req;
  logic        busy;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  muldiv_ctrl #(
    .MUL_STAGES(MulStages),
    .DIV_BITS  (32)
  ) u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_op   (req_op),
    .srca     (srca),
    .srcb     (srcb),
    .flush    (flush),
    .stall_req(stall_req),
    .busy     (busy),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic hwe, input logic lwe, input logic [31:0] hi,
                              input logic [31:0] lo);
    exp_t e;
    e.hwe = hwe;
    e.lwe = lwe;
    e.hi  = hi;
    e.lo  = lo;
    return e;
  endfunction

  // Reference HI/LO result for ops 0..3.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sp;
    logic        [63:0] up;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    sa = a;
    sb = b;
    case (op)
      3'd0: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return mk(1'b1, 1'b1, sp[63:32], sp[31:0]);
      end
      3'd1: begin
        up = {32'd0, a} * {32'd0, b};
        return mk(1'b1, 1'b1, up[63:32], up[31:0]);
      end
      default: begin
        if (b == '0) return mk(1'b1, 1'b1, a, 32'hFFFF_FFFF);
        if (op == 3'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          return mk(1'b1, 1'b1, sr, sq);
        end
        return mk(1'b1, 1'b1, a % b, a / b);
      end
    endcase
  endfunction

  // Monitor: inputs change on negedge, outputs settle well before this sample point.
  always begin
    @(negedge clk);
    #2;
    if (hi_we || lo_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 64'({hi_we, lo_we}), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("we", 64'({hi_we, lo_we}), 64'({mon_e.hwe, mon_e.lwe}));
        if (mon_e.hwe) check("hi_wdata", 64'(hi_wdata), 64'(mon_e.hi));
        if (mon_e.lwe) check("lo_wdata", 64'(lo_wdata), 64'(mon_e.lo));
      end
    end
  end

  // Present one request, count stall cycles; returns during the DONE (or MTxx) cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_stall, input exp_t e);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    srca      = a;
    srcb      = b;
    exp_q.push_back(e);
    n = 0;
    #1;
    while (stall_req && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", 64'(n), 64'(exp_stall));
    if (exp_stall > 0) check("busy_in_done", 64'(busy), 64'd1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("busy_after_done", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          st;

    #3;
    check("reset_outs", {busy, stall_req, hi_we, lo_we, hi_wdata, lo_wdata[27:0]}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, MulStages + 1, mk(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1));
    go_idle();
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulStages + 1, mk(1, 1, 32'hFFFF_FFFE, 32'h1));
    go_idle();
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 33, mk(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
    // Back-to-back: next request presented in the IDLE cycle right after DONE.
    run_op(3'd3, 32'd100, 32'd7, 33, mk(1, 1, 32'd2, 32'd14));
    run_op(3'd3, 32'h1234_5678, 32'd0, 1, mk(1, 1, 32'h1234_5678, 32'hFFFF_FFFF));
    run_op(3'd4, 32'hCAFE_0001, 32'd0, 0, mk(1, 0, 32'hCAFE_0001, 32'd0));
    go_idle();
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 33, model(3'd2, 32'd7, 32'hFFFF_FFFE));
    go_idle();

    // Flush mid-divide on cycle 10 of the operation.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd2;
    srca      = 32'hFFFF_FFF9;
    srcb      = 32'd2;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_idle", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    run_op(3'd5, 32'h0000_ABCD, 32'd0, 0, mk(0, 1, 32'd0, 32'h0000_ABCD));
    go_idle();

    // Flush landing on the DONE cycle suppresses the write.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    srca      = 32'd9;
    srcb      = 32'd9;
    repeat (MulStages + 1) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_done_we", 64'({hi_we, lo_we}), 64'd0);
    check("flush_done_busy", 64'(busy), 64'd1);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_done_idle", 64'(busy), 64'd0);

    // Requests presented with flush are not accepted.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd4;
    srca      = 32'h5555_5555;
    flush     = 1'b1;
    #1;
    check("flush_mt_we", 64'({hi_we, lo_we, stall_req}), 64'd0);
    req_op = 3'd1;
    #1;
    check("flush_req_stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_req_idle", 64'(busy), 64'd0);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd3;
    srca      = 32'd1000;
    srcb      = 32'd3;
    repeat (5) @(negedge clk);
    req_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("rst_mid_outs", {busy, stall_req, hi_we, lo_we, hi_wdata, lo_wdata[27:0]}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(3'd0, 32'd2, 32'd3, MulStages + 1, mk(1, 1, 32'd0, 32'd6));
    go_idle();

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i == 5) ? 32'd0 : $urandom;
      if (i[0]) b = b >> $urandom_range(0, 31);
      st = (op < 3'd2) ? (MulStages + 1) : ((b == '0) ? 1 : 33);
      run_op(op, a, b, st, model(op, a, b));
      go_idle();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
